// File: rtl/bsg_mem_1r1w_sync_reader_pkg.sv
// rtl/bsg_mem_1r1w_sync_reader_pkg.sv - width helpers for the 1r1w sync RAM reader
package bsg_mem_1r1w_sync_reader_pkg;

  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/bsg_mem_1r1w_sync_reader_two_fifo.sv
// rtl/bsg_mem_1r1w_sync_reader_two_fifo.sv - 2-entry ready/valid-in, valid/yumi-out buffer
module bsg_mem_1r1w_sync_reader_two_fifo #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i,
  output logic [1:0]         count_o
);

  logic [1:0][width_p-1:0] mem_q, mem_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic                    wr_ptr_q, wr_ptr_d;
  logic [1:0]              cnt_q, cnt_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q + {1'b0, v_i} - {1'b0, yumi_i};
    // At count 2 the write slot is the head being dequeued at this same edge.
    if (v_i) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (yumi_i) begin
      rd_ptr_d = ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign v_o     = (cnt_q != 2'd0);
  assign ready_o = (cnt_q != 2'd2) | yumi_i;
  assign count_o = cnt_q;

endmodule

// File: rtl/bsg_mem_1r1w_sync_reader.sv
// rtl/bsg_mem_1r1w_sync_reader.sv - read-side controller for a circular sync-read 1r1w RAM
module bsg_mem_1r1w_sync_reader
  import bsg_mem_1r1w_sync_reader_pkg::*;
#(
  parameter int width_p       = 8,
  parameter int els_p         = 8,
  parameter int addr_width_lp = safe_clog2(els_p),
  parameter int ptr_width_lp  = addr_width_lp + 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [ptr_width_lp-1:0]  w_ptr_i,
  output logic                     r_v_o,
  output logic [addr_width_lp-1:0] r_addr_o,
  input  logic [width_p-1:0]       r_data_i,
  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  input  logic                     yumi_i,
  output logic [ptr_width_lp-1:0]  r_ptr_o
);

  if (!is_pow2(els_p)) begin : g_bad_els
    $error("els_p must be a power of two and at least 2");
  end

  logic [ptr_width_lp-1:0] r_ptr_q, r_ptr_d;
  logic [ptr_width_lp-1:0] occupancy;
  logic                    inflight_q, inflight_d;
  logic [1:0]              buf_cnt, credit, limit;
  logic                    issue;
  logic                    fifo_ready;

  always_comb begin
    occupancy  = w_ptr_i - r_ptr_q;
    // Credit counts buffered plus returning words; a yumi frees one slot this edge.
    credit     = buf_cnt + {1'b0, inflight_q};
    limit      = 2'd1 + {1'b0, yumi_i};
    issue      = ~reset_i & (occupancy != '0) & (credit <= limit);
    r_ptr_d    = r_ptr_q;
    inflight_d = issue;
    if (issue) begin
      r_ptr_d = r_ptr_q + ptr_width_lp'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_ptr_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      r_ptr_q    <= r_ptr_d;
      inflight_q <= inflight_d;
    end
  end

  assign r_v_o    = issue;
  assign r_addr_o = r_ptr_q[addr_width_lp-1:0];
  assign r_ptr_o  = r_ptr_q;

  bsg_mem_1r1w_sync_reader_two_fifo #(
    .width_p(width_p)
  ) out_buf (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .v_i    (inflight_q),
    .data_i (r_data_i),
    .ready_o(fifo_ready),
    .v_o    (v_o),
    .data_o (data_o),
    .yumi_i (yumi_i),
    .count_o(buf_cnt)
  );

`ifndef SYNTHESIS
  a_yumi_without_valid: assert property (@(posedge clk_i) disable iff (reset_i)
    !(yumi_i && !v_o)) else $error("yumi_i asserted while v_o is low");

  a_occupancy_range: assert property (@(posedge clk_i) disable iff (reset_i)
    occupancy <= ptr_width_lp'(els_p)) else $error("occupancy exceeds els_p");

  a_buffer_room: assert property (@(posedge clk_i) disable iff (reset_i)
    !(inflight_q && !fifo_ready)) else $error("output buffer overflow");
`endif

endmodule

// File: tb/tb_bsg_mem_1r1w_sync_reader.sv
// tb/tb_bsg_mem_1r1w_sync_reader.sv - self-checking bench for bsg_mem_1r1w_sync_reader
module tb_bsg_mem_1r1w_sync_reader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] w_ptr = 4'd0;
  logic       r_v;
  logic [2:0] r_addr;
  logic [7:0] r_data = 8'd0;
  logic       v;
  logic [7:0] data;
  logic       yumi = 1'b0;
  logic [3:0] r_ptr;

  logic       we = 1'b0;
  logic [7:0] wdata = 8'd0;
  logic [7:0] mem [8];

  int errors = 0;
  int checks = 0;

  logic [7:0] pending [$];
  logic [7:0] expq [$];
  logic       rst_req = 1'b1;
  int         issue_cnt = 0;
  bit         full_seen = 1'b0;

  logic       s_rv, s_v;
  logic [2:0] s_raddr;
  logic [7:0] s_data;
  logic [3:0] s_rptr;

  typedef struct {
    int         nwords;
    int         ymode;
    logic [3:0] exp_rptr;
  } vec_t;
  vec_t vecs [4];

  bsg_mem_1r1w_sync_reader #(
    .width_p(8),
    .els_p  (8)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .w_ptr_i (w_ptr),
    .r_v_o   (r_v),
    .r_addr_o(r_addr),
    .r_data_i(r_data),
    .v_o     (v),
    .data_o  (data),
    .yumi_i  (yumi),
    .r_ptr_o (r_ptr)
  );

  always #5 clk = ~clk;

  // Writer side and synchronous-read RAM; the pointer moves the cycle after the write edge.
  always @(posedge clk) begin
    if (we) mem[w_ptr[2:0]] <= wdata;
    if (r_v) r_data <= mem[r_addr];
    if (reset) w_ptr <= 4'd0;
    else if (we) w_ptr <= w_ptr + 4'd1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input bit want_yumi);
    logic [3:0] occ;
    logic [7:0] e;
    @(negedge clk);
    reset = rst_req;
    yumi  = want_yumi & v & ~rst_req;
    occ   = w_ptr - r_ptr;
    if (!rst_req && pending.size() > 0 && occ < 4'd8) begin
      we    = 1'b1;
      wdata = pending.pop_front();
      expq.push_back(wdata);
    end else begin
      we = 1'b0;
    end
    #1;
    s_rv    = r_v;
    s_raddr = r_addr;
    s_v     = v;
    s_data  = data;
    s_rptr  = r_ptr;
    if (r_v) issue_cnt++;
    if ((w_ptr - r_ptr) == 4'd8) full_seen = 1'b1;
    if (yumi) begin
      if (expq.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = expq.pop_front();
        chk("sb_data", {24'd0, data}, {24'd0, e});
      end
    end
  endtask

  task automatic do_reset(input int n);
    pending.delete();
    expq.delete();
    rst_req = 1'b1;
    repeat (n) cyc(1'b0);
    rst_req = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    bit done;
    int nbubble, ndeliv;
    bit seen7, seen8, seen15, wrapped;
    bit want;

    vecs[0] = '{5, 0, 4'd11};
    vecs[1] = '{9, 1, 4'd4};
    vecs[2] = '{12, 2, 4'd0};
    vecs[3] = '{12, 3, 4'd12};

    do_reset(3);

    // Empty start.
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1);
      chk("empty_rv", {31'd0, s_rv}, 32'd0);
      chk("empty_v", {31'd0, s_v}, 32'd0);
    end
    chk("empty_rptr", {28'd0, s_rptr}, 32'd0);

    // Single word: issue the cycle the pointer moves, output two cycles later.
    pending.push_back(8'hA5);
    cyc(1'b1);
    chk("single_noissue_before", {31'd0, s_rv}, 32'd0);
    cyc(1'b1);
    chk("single_rv", {31'd0, s_rv}, 32'd1);
    chk("single_raddr", {29'd0, s_raddr}, 32'd0);
    cyc(1'b1);
    chk("single_v_t1", {31'd0, s_v}, 32'd0);
    cyc(1'b1);
    chk("single_v_t2", {31'd0, s_v}, 32'd1);
    chk("single_data", {24'd0, s_data}, 32'hA5);
    cyc(1'b1);
    chk("single_v_after", {31'd0, s_v}, 32'd0);
    chk("single_rptr", {28'd0, s_rptr}, 32'd1);

    // Streaming 16 words through 8 slots with yumi held high.
    do_reset(2);
    for (int i = 0; i < 16; i++) pending.push_back(8'(i));
    nbubble = 0; ndeliv = 0;
    seen7 = 0; seen8 = 0; seen15 = 0; wrapped = 0;
    for (int c = 0; c < 100 && ndeliv < 16; c++) begin
      cyc(1'b1);
      if (s_rptr == 4'd7) seen7 = 1;
      if (s_rptr == 4'd8 && seen7) seen8 = 1;
      if (s_rptr == 4'd15 && seen8) seen15 = 1;
      if (s_rptr == 4'd0 && seen15) wrapped = 1;
      if (s_v) ndeliv++;
      else if (ndeliv > 0) nbubble++;
    end
    chk("stream_count", ndeliv, 32'd16);
    chk("stream_bubbles", nbubble, 32'd0);
    chk("stream_wrap", {31'd0, seen8 & seen15 & wrapped}, 32'd1);
    chk("stream_rptr", {28'd0, s_rptr}, 32'd0);

    // Backpressure: six words queued, consumer stalled.
    for (int i = 0; i < 6; i++) pending.push_back(8'(8'h40 + i));
    issue_cnt = 0;
    repeat (10) cyc(1'b0);
    chk("bp_issues", issue_cnt, 32'd2);
    chk("bp_rptr", {28'd0, s_rptr}, 32'd2);
    chk("bp_v", {31'd0, s_v}, 32'd1);
    done = 0;
    for (int c = 0; c < 50 && !done; c++) begin
      cyc(1'b1);
      if (pending.size() == 0 && expq.size() == 0) done = 1;
    end
    chk("bp_drained", {31'd0, done}, 32'd1);
    repeat (3) cyc(1'b1);
    chk("bp_rptr_end", {28'd0, s_rptr}, 32'd6);

    // Table: yumi patterns 0=always, 1=alternate, 2=random, 3=hold until RAM full.
    for (int k = 0; k < 4; k++) begin
      if (vecs[k].ymode == 3) do_reset(2);
      for (int i = 0; i < vecs[k].nwords; i++) pending.push_back(8'($urandom));
      full_seen = 0;
      done = 0;
      for (int c = 0; c < 400 && !done; c++) begin
        case (vecs[k].ymode)
          0:       want = 1'b1;
          1:       want = c[0];
          2:       want = 1'($urandom_range(0, 1));
          default: want = full_seen;
        endcase
        cyc(want);
        if (pending.size() == 0 && expq.size() == 0) done = 1;
      end
      chk($sformatf("vec%0d_done", k), {31'd0, done}, 32'd1);
      repeat (3) cyc(1'b1);
      chk($sformatf("vec%0d_rptr", k), {28'd0, s_rptr}, {28'd0, vecs[k].exp_rptr});
      chk($sformatf("vec%0d_idle_v", k), {31'd0, s_v}, 32'd0);
      if (vecs[k].ymode == 3) chk("vec_full_reached", {31'd0, full_seen}, 32'd1);
    end

    // Reset the cycle after the second issue; returning data must be dropped.
    do_reset(2);
    for (int i = 0; i < 3; i++) pending.push_back(8'(8'h70 + i));
    issue_cnt = 0;
    for (int c = 0; c < 20 && issue_cnt < 2; c++) cyc(1'b0);
    chk("rst_issue_seen", issue_cnt, 32'd2);
    rst_req = 1'b1;
    cyc(1'b0);
    chk("rst_rv_in_reset", {31'd0, s_rv}, 32'd0);
    rst_req = 1'b0;
    pending.delete();
    expq.delete();
    cyc(1'b1);
    chk("rst_v_after", {31'd0, s_v}, 32'd0);
    chk("rst_rptr", {28'd0, s_rptr}, 32'd0);
    cyc(1'b1);
    chk("rst_v_after2", {31'd0, s_v}, 32'd0);
    chk("rst_rv_after2", {31'd0, s_rv}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
